// File: rtl/ctech_clk_gate_pkg.sv
// Shared types and sizing helper for the ctech clock-gate enable controller.
package ctech_clk_gate_pkg;

    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StWake  = 3'd1,
        StOn    = 3'd2,
        StIdle  = 3'd3,
        StDrain = 3'd4
    } clk_gate_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ctech_lib_clk_gate_sat_cnt.sv
// Clearable up-counter that holds at MAX instead of wrapping.
module ctech_lib_clk_gate_sat_cnt #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ctech_lib_clk_gate_ctrl.sv
// Enable-side controller for the clock-AND gating cell: req/ack handshake with wake-up delay,
// minimum on-time, idle timeout and a one-cycle drain before the enable drops.
module ctech_lib_clk_gate_ctrl
    import ctech_clk_gate_pkg::*;
#(
    parameter int unsigned WAKE_CYC   = 4,
    parameter int unsigned IDLE_CYC   = 16,
    parameter int unsigned MIN_ON_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_req,
    input  logic       busy,
    input  logic       force_on,
    output logic       clk_en,
    output logic       clk_ack,
    output logic [2:0] state_o
);

    localparam int unsigned MaxWi  = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
    localparam int unsigned MaxCyc = (MaxWi > MIN_ON_CYC) ? MaxWi : MIN_ON_CYC;
    localparam int unsigned CntW   = cnt_width(MaxCyc);

    localparam logic [CntW-1:0] WakeLast = CntW'(WAKE_CYC - 1);
    localparam logic [CntW-1:0] IdleLast = CntW'(IDLE_CYC - 1);
    localparam logic [CntW-1:0] MinOn    = CntW'(MIN_ON_CYC);

    clk_gate_state_e state_q, state_d;
    logic            clk_en_q, clk_en_d;
    logic            clk_ack_q, clk_ack_d;
    logic [CntW-1:0] wake_cnt, idle_cnt, on_cnt;
    logic            wake_req;
    logic            min_on_met;

    assign wake_req   = clk_req | busy;
    // on_cnt saturates at MIN_ON_CYC, so equality means the minimum has been served.
    assign min_on_met = (MIN_ON_CYC == 0) || (on_cnt == MinOn);

    ctech_lib_clk_gate_sat_cnt #(.WIDTH(CntW), .MAX(WAKE_CYC - 1)) u_wake_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q != StWake),
        .inc (state_q == StWake),
        .cnt (wake_cnt)
    );

    ctech_lib_clk_gate_sat_cnt #(.WIDTH(CntW), .MAX(IDLE_CYC - 1)) u_idle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q != StIdle),
        .inc (state_q == StIdle),
        .cnt (idle_cnt)
    );

    // Held clear while OFF so every OFF->WAKE starts min-on from zero; DRAIN->WAKE keeps it.
    ctech_lib_clk_gate_sat_cnt #(.WIDTH(CntW), .MAX(MIN_ON_CYC)) u_on_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q == StOff),
        .inc (state_q != StOff),
        .cnt (on_cnt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOff:   if (wake_req) state_d = StWake;
            StWake:  if (wake_cnt == WakeLast) state_d = StOn;
            StOn:    if (!wake_req) state_d = StIdle;
            StIdle: begin
                // Returning activity wins over a coincident timeout.
                if (wake_req) begin
                    state_d = StOn;
                end else if ((idle_cnt == IdleLast) && min_on_met) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = wake_req ? StWake : StOff;
            default: state_d = StOff;
        endcase
        clk_en_d  = (state_d != StOff) | force_on;
        clk_ack_d = (state_d == StOn) || (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StOff;
            clk_en_q  <= 1'b0;
            clk_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_en_q  <= clk_en_d;
            clk_ack_q <= clk_ack_d;
        end
    end

    assign clk_en  = clk_en_q;
    assign clk_ack = clk_ack_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ctech_lib_clk_gate_ctrl.sv
// Directed bench for ctech_lib_clk_gate_ctrl: default instance plus a long-min-on instance.
module tb_ctech_lib_clk_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_req = 1'b0, busy = 1'b0, force_on = 1'b0;
    logic       clk_en, clk_ack;
    logic [2:0] state_o;
    logic       req2 = 1'b0, busy2 = 1'b0, force2 = 1'b0;
    logic       en2, ack2;
    logic [2:0] st2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ctech_lib_clk_gate_ctrl #(.WAKE_CYC(4), .IDLE_CYC(16), .MIN_ON_CYC(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_req  (clk_req),
        .busy     (busy),
        .force_on (force_on),
        .clk_en   (clk_en),
        .clk_ack  (clk_ack),
        .state_o  (state_o)
    );

    ctech_lib_clk_gate_ctrl #(.WAKE_CYC(4), .IDLE_CYC(2), .MIN_ON_CYC(40)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .clk_req  (req2),
        .busy     (busy2),
        .force_on (force2),
        .clk_en   (en2),
        .clk_ack  (ack2),
        .state_o  (st2)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        tests++; if (clk_en !== 1'b0) begin fails++; $display("FAIL rst_en got=%b exp=0", clk_en); end
        tests++; if (clk_ack !== 1'b0) begin fails++; $display("FAIL rst_ack got=%b exp=0", clk_ack); end
        tests++; if (state_o !== 3'd0) begin fails++; $display("FAIL rst_state got=%0d exp=0", state_o); end
        rst = 1'b0;
        tick(1);
        tests++; if (state_o !== 3'd0) begin fails++; $display("FAIL rst_idle_state got=%0d exp=0", state_o); end
        tests++; if (st2 !== 3'd0) begin fails++; $display("FAIL rst_dut2_state got=%0d exp=0", st2); end
    endtask

    task automatic test_wake();
        clk_req = 1'b1;
        tick(1);
        tests++; if (clk_en !== 1'b1) begin fails++; $display("FAIL wake_en got=%b exp=1", clk_en); end
        tests++; if (clk_ack !== 1'b0) begin fails++; $display("FAIL wake_ack0 got=%b exp=0", clk_ack); end
        tests++; if (state_o !== 3'd1) begin fails++; $display("FAIL wake_state got=%0d exp=1", state_o); end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            tests++;
            if (clk_ack !== 1'b0 || state_o !== 3'd1) begin
                fails++; $display("FAIL wake_hold[%0d] ack=%b st=%0d exp ack=0 st=1", i, clk_ack, state_o);
            end
        end
        tick(1);
        tests++; if (clk_ack !== 1'b1) begin fails++; $display("FAIL wake_ack1 got=%b exp=1", clk_ack); end
        tests++; if (state_o !== 3'd2) begin fails++; $display("FAIL wake_on got=%0d exp=2", state_o); end
        tests++; if (clk_en !== 1'b1) begin fails++; $display("FAIL wake_en_on got=%b exp=1", clk_en); end
    endtask

    task automatic test_idle_off();
        tick(10);
        clk_req = 1'b0;
        tick(1);
        tests++; if (state_o !== 3'd3 || clk_ack !== 1'b1) begin
            fails++; $display("FAIL idle_enter st=%0d ack=%b exp st=3 ack=1", state_o, clk_ack); end
        for (int i = 1; i < 16; i++) begin
            tick(1);
            tests++;
            if (state_o !== 3'd3) begin fails++; $display("FAIL idle_hold[%0d] got=%0d exp=3", i, state_o); end
        end
        tick(1);
        tests++; if (state_o !== 3'd4 || clk_ack !== 1'b0 || clk_en !== 1'b1) begin
            fails++; $display("FAIL drain st=%0d ack=%b en=%b exp st=4 ack=0 en=1", state_o, clk_ack, clk_en); end
        tick(1);
        tests++; if (state_o !== 3'd0 || clk_en !== 1'b0 || clk_ack !== 1'b0) begin
            fails++; $display("FAIL gate_off st=%0d en=%b ack=%b exp st=0 en=0 ack=0", state_o, clk_en, clk_ack); end
    endtask

    task automatic test_back_to_back();
        clk_req = 1'b1;
        tick(5);
        tests++; if (state_o !== 3'd2) begin fails++; $display("FAIL b2b_on got=%0d exp=2", state_o); end
        tick(10);
        clk_req = 1'b0;
        tick(16);
        tests++; if (state_o !== 3'd3) begin fails++; $display("FAIL b2b_idle15 got=%0d exp=3", state_o); end
        // Activity returns on the same cycle the idle timeout would fire.
        busy = 1'b1;
        tick(1);
        tests++; if (state_o !== 3'd2 || clk_ack !== 1'b1) begin
            fails++; $display("FAIL b2b_reon st=%0d ack=%b exp st=2 ack=1", state_o, clk_ack); end
        busy = 1'b0;
        tick(17);
        tests++; if (state_o !== 3'd4) begin fails++; $display("FAIL b2b_drain got=%0d exp=4", state_o); end
        clk_req = 1'b1;
        tick(1);
        tests++; if (state_o !== 3'd1 || clk_en !== 1'b1 || clk_ack !== 1'b0) begin
            fails++; $display("FAIL b2b_rewake st=%0d en=%b ack=%b exp st=1 en=1 ack=0", state_o, clk_en, clk_ack); end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            tests++;
            if (clk_en !== 1'b1 || clk_ack !== 1'b0) begin
                fails++; $display("FAIL b2b_wake[%0d] en=%b ack=%b exp en=1 ack=0", i, clk_en, clk_ack);
            end
        end
        tick(1);
        tests++; if (clk_ack !== 1'b1 || state_o !== 3'd2) begin
            fails++; $display("FAIL b2b_ack ack=%b st=%0d exp ack=1 st=2", clk_ack, state_o); end
        clk_req = 1'b0;
        tick(18);
        tests++; if (state_o !== 3'd0 || clk_en !== 1'b0) begin
            fails++; $display("FAIL b2b_off st=%0d en=%b exp st=0 en=0", state_o, clk_en); end
    endtask

    task automatic test_force_on();
        force_on = 1'b1;
        tick(1);
        tests++; if (clk_en !== 1'b1 || clk_ack !== 1'b0 || state_o !== 3'd0) begin
            fails++; $display("FAIL force_on en=%b ack=%b st=%0d exp en=1 ack=0 st=0", clk_en, clk_ack, state_o); end
        tick(3);
        tests++; if (clk_en !== 1'b1 || state_o !== 3'd0) begin
            fails++; $display("FAIL force_hold en=%b st=%0d exp en=1 st=0", clk_en, state_o); end
        force_on = 1'b0;
        tick(1);
        tests++; if (clk_en !== 1'b0) begin fails++; $display("FAIL force_off got=%b exp=0", clk_en); end
    endtask

    task automatic test_reset_mid();
        clk_req = 1'b1;
        tick(5);
        tests++; if (clk_ack !== 1'b1) begin fails++; $display("FAIL rmid_on got=%b exp=1", clk_ack); end
        rst = 1'b1;
        tick(1);
        tests++; if (clk_en !== 1'b0 || clk_ack !== 1'b0 || state_o !== 3'd0) begin
            fails++; $display("FAIL rmid_rst en=%b ack=%b st=%0d exp 0/0/0", clk_en, clk_ack, state_o); end
        rst = 1'b0;
        tick(1);
        tests++; if (clk_en !== 1'b1 || state_o !== 3'd1) begin
            fails++; $display("FAIL rmid_wake en=%b st=%0d exp en=1 st=1", clk_en, state_o); end
        tick(3);
        tests++; if (clk_ack !== 1'b0) begin fails++; $display("FAIL rmid_early_ack got=%b exp=0", clk_ack); end
        tick(1);
        tests++; if (clk_ack !== 1'b1) begin fails++; $display("FAIL rmid_ack got=%b exp=1", clk_ack); end
        clk_req = 1'b0;
    endtask

    task automatic test_min_on();
        int   en_cycles;
        logic [2:0] prev_st;
        req2 = 1'b1;
        tick(1);
        req2 = 1'b0;
        en_cycles = 0;
        prev_st = st2;
        tests++; if (en2 !== 1'b1) begin fails++; $display("FAIL minon_rise got=%b exp=1", en2); end
        if (en2 === 1'b1) en_cycles = 1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (en2 !== 1'b1) break;
            en_cycles++;
            prev_st = st2;
        end
        tests++; if (en_cycles != 42) begin
            fails++; $display("FAIL minon_cycles got=%0d exp=42", en_cycles); end
        tests++; if (prev_st !== 3'd4) begin
            fails++; $display("FAIL minon_drain_last got=%0d exp=4", prev_st); end
        tests++; if (st2 !== 3'd0 || ack2 !== 1'b0) begin
            fails++; $display("FAIL minon_off st=%0d ack=%b exp st=0 ack=0", st2, ack2); end
    endtask

    initial begin
        tick(1);
        test_reset();
        tick(5);
        test_wake();
        test_idle_off();
        tick(2);
        test_back_to_back();
        tick(2);
        test_force_on();
        tick(2);
        test_reset_mid();
        tick(2);
        test_min_on();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
